// File: rtl/raymarch_pkg.sv
// Shared raymarcher definitions: screen geometry, pixel FIFO entry, colour packing.
package raymarch_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CORDW         = 10;
  localparam int INDEXW        = 19;

  typedef struct packed {
    logic              last;
    logic [INDEXW-1:0] index;
    logic [7:0]        rgb;
  } pix_entry_t;

  function automatic logic [7:0] rgb332(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head shows the oldest entry while not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers raymarcher pixels and writes them as RGB332 bytes over Avalon-MM.
// Optional ordered dither enabled by defining PWB_DITHER_EN.
module pixel_write_buffer
  import raymarch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [CORDW-1:0] i_pixel_x,
  input  logic [CORDW-1:0] i_pixel_y,
  input  logic [7:0]       i_red,
  input  logic [7:0]       i_green,
  input  logic [7:0]       i_blue,
  output logic [31:0]      o_mem_address,
  output logic             o_mem_write,
  output logic [7:0]       o_mem_writedata,
  input  logic             i_mem_waitrequest,
  output logic             o_frame_done,
  output logic             o_overflow,
  output logic [15:0]      o_drop_count
);

  localparam logic [CORDW-1:0] XLIM = CORDW'(SCREEN_WIDTH);
  localparam logic [CORDW-1:0] YLIM = CORDW'(SCREEN_HEIGHT);

  pix_entry_t        in_entry;
  pix_entry_t        head;
  logic              accept;
  logic              full;
  logic              empty;
  logic              drop;
  logic              fire;
  logic              load;
  logic              stg_last;
  logic [INDEXW-1:0] yw;
  logic [7:0]        r_c;
  logic [7:0]        g_c;
  logic [7:0]        b_c;

  assign accept = i_valid && (i_pixel_x < XLIM) && (i_pixel_y < YLIM);
  assign drop   = accept && full;
  assign fire   = o_mem_write && !i_mem_waitrequest;
  assign load   = !empty && (!o_mem_write || fire);
  assign yw     = INDEXW'(i_pixel_y);

`ifdef PWB_DITHER_EN
  logic [1:0] bayer;
  logic [8:0] r_s;
  logic [8:0] g_s;
  logic [8:0] b_s;

  always_comb begin
    case ({i_pixel_x[0], i_pixel_y[0]})
      2'b00:   bayer = 2'd0;
      2'b10:   bayer = 2'd2;
      2'b01:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
  end

  assign r_s = {1'b0, i_red}   + {4'd0, bayer, 3'd0};
  assign g_s = {1'b0, i_green} + {4'd0, bayer, 3'd0};
  assign b_s = {1'b0, i_blue}  + {3'd0, bayer, 4'd0};
  assign r_c = r_s[8] ? 8'hFF : r_s[7:0];
  assign g_c = g_s[8] ? 8'hFF : g_s[7:0];
  assign b_c = b_s[8] ? 8'hFF : b_s[7:0];
`else
  assign r_c = i_red;
  assign g_c = i_green;
  assign b_c = i_blue;
`endif

  // y*640 = (y<<9) + (y<<7)
  assign in_entry.index = (yw << 9) + (yw << 7) + INDEXW'(i_pixel_x);
  assign in_entry.rgb   = rgb332(r_c, g_c, b_c);
  assign in_entry.last  = (i_pixel_x == XLIM - 1'b1) &&
                          (i_pixel_y == YLIM - 1'b1);

  sync_fifo #(
    .WIDTH ($bits(pix_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (load),
    .din   (in_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      o_mem_write     <= 1'b0;
      o_mem_address   <= '0;
      o_mem_writedata <= '0;
      stg_last        <= 1'b0;
      o_frame_done    <= 1'b0;
    end else begin
      o_frame_done <= fire && stg_last;
      if (load) begin
        o_mem_write     <= 1'b1;
        o_mem_address   <= BASE_ADDR + {{(32-INDEXW){1'b0}}, head.index};
        o_mem_writedata <= head.rgb;
        stg_last        <= head.last;
      end else if (fire) begin
        o_mem_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Randomised and directed bench for pixel_write_buffer against a queue model.
module tb_pixel_write_buffer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [9:0]  i_pixel_x;
  logic [9:0]  i_pixel_y;
  logic [7:0]  i_red;
  logic [7:0]  i_green;
  logic [7:0]  i_blue;
  logic [31:0] o_mem_address;
  logic        o_mem_write;
  logic [7:0]  o_mem_writedata;
  logic        i_mem_waitrequest;
  logic        o_frame_done;
  logic        o_overflow;
  logic [15:0] o_drop_count;

  always #5 clk = ~clk;

  pixel_write_buffer #(
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_valid           (i_valid),
    .i_pixel_x         (i_pixel_x),
    .i_pixel_y         (i_pixel_y),
    .i_red             (i_red),
    .i_green           (i_green),
    .i_blue            (i_blue),
    .o_mem_address     (o_mem_address),
    .o_mem_write       (o_mem_write),
    .o_mem_writedata   (o_mem_writedata),
    .i_mem_waitrequest (i_mem_waitrequest),
    .o_frame_done      (o_frame_done),
    .o_overflow        (o_overflow),
    .o_drop_count      (o_drop_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: colour rule, pixel queue, single held write.
  typedef struct {
    int       addr;
    bit [7:0] data;
    bit       last;
  } ent_t;

  function automatic bit [7:0] pack(int x, int y, int r, int g, int b);
    bit [7:0] rr;
    bit [7:0] gg;
    bit [7:0] bb;
`ifdef PWB_DITHER_EN
    int bay;
    int tbl [4] = '{0, 3, 2, 1};
    bay = tbl[(x % 2) * 2 + (y % 2)];
    r = (r + bay * 8  > 255) ? 255 : r + bay * 8;
    g = (g + bay * 8  > 255) ? 255 : g + bay * 8;
    b = (b + bay * 16 > 255) ? 255 : b + bay * 16;
`endif
    rr = 8'(r);
    gg = 8'(g);
    bb = 8'(b);
    return {rr[7:5], gg[7:5], bb[7:6]};
  endfunction

  ent_t q[$];
  ent_t m_s;
  bit   m_sv  = 0;
  bit   m_ovf = 0;
  int   m_dc  = 0;
  bit   m_fd  = 0;

  always @(posedge clk) begin
    bit fire;
    bit full;
    bit acc;
    ent_t e;
    if (reset) begin
      q.delete();
      m_sv  = 0;
      m_ovf = 0;
      m_dc  = 0;
      m_fd  = 0;
    end else begin
      fire = m_sv && !i_mem_waitrequest;
      m_fd = fire && m_s.last;
      full = (q.size() >= DEPTH);
      acc  = i_valid && i_pixel_x < 640 && i_pixel_y < 480;
      if (q.size() > 0 && (!m_sv || fire)) begin
        m_s  = q.pop_front();
        m_sv = 1;
      end else if (fire) begin
        m_sv = 0;
      end
      if (acc) begin
        if (full) begin
          m_ovf = 1;
          if (m_dc < 65535) m_dc++;
        end else begin
          e.addr = int'(BASE) + int'(i_pixel_y) * 640 + int'(i_pixel_x);
          e.data = pack(int'(i_pixel_x), int'(i_pixel_y), int'(i_red),
                        int'(i_green), int'(i_blue));
          e.last = (i_pixel_x == 639 && i_pixel_y == 479);
          q.push_back(e);
        end
      end
    end
  end

  bit          chk_en = 0;
  bit          hold   = 0;
  logic [31:0] h_addr;
  logic [7:0]  h_data;
  int          wr_cnt = 0;
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("write", 32'(o_mem_write), 32'(m_sv));
      if (m_sv) begin
        check("address", o_mem_address, 32'(m_s.addr));
        check("writedata", 32'(o_mem_writedata), 32'(m_s.data));
      end
      check("overflow", 32'(o_overflow), 32'(m_ovf));
      check("drop_count", 32'(o_drop_count), 32'(m_dc));
      check("frame_done", 32'(o_frame_done), 32'(m_fd));
      if (hold) begin
        check("hold_write", 32'(o_mem_write), 32'd1);
        check("hold_address", o_mem_address, h_addr);
        check("hold_data", 32'(o_mem_writedata), 32'(h_data));
      end
      hold   = o_mem_write && i_mem_waitrequest && !reset;
      h_addr = o_mem_address;
      h_data = o_mem_writedata;
      if (o_mem_write) wr_cnt++;
      if (o_frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input int r, input int g,
                     input int b);
    i_valid   = 1'b1;
    i_pixel_x = 10'(x);
    i_pixel_y = 10'(y);
    i_red     = 8'(r);
    i_green   = 8'(g);
    i_blue    = 8'(b);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    i_valid           = 1'b0;
    i_pixel_x         = '0;
    i_pixel_y         = '0;
    i_red             = '0;
    i_green           = '0;
    i_blue            = '0;
    i_mem_waitrequest = 1'b0;
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_write", 32'(o_mem_write), 32'd0);
    check("reset_addr", o_mem_address, 32'd0);
    check("reset_drop", 32'(o_drop_count), 32'd0);
    check("reset_ovf", 32'(o_overflow), 32'd0);

    // Single pixel latency and packing
    pix(2, 1, 8'hFF, 8'h00, 8'h80);
    tick();
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t1_write", 32'(o_mem_write), 32'd1);
    check("t1_addr", o_mem_address, BASE + 32'd642);
    check("t1_data", 32'(o_mem_writedata), 32'hE2);
    repeat (3) tick();

    // Stall with 20 pixels streaming
    do_reset();
    i_mem_waitrequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pix(i, 3, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255));
      tick();
    end
    i_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("t2_drop", 32'(o_drop_count), 32'd3);
    check("t2_ovf", 32'(o_overflow), 32'd1);
    i_mem_waitrequest = 1'b0;
    wr_cnt = 0;
    repeat (24) tick();
    check("t2_writes", 32'(wr_cnt), 32'd17);

    // Off-screen coordinates are discarded silently
    do_reset();
    pix(640, 5, 1, 2, 3);
    tick();
    pix(3, 480, 1, 2, 3);
    tick();
    pix(640, 480, 1, 2, 3);
    tick();
    i_valid = 1'b0;
    wr_cnt = 0;
    repeat (4) tick();
    check("t3_writes", 32'(wr_cnt), 32'd0);
    check("t3_drop", 32'(o_drop_count), 32'd0);

    // Reset while stalled with 8 queued entries
    i_mem_waitrequest = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pix(100 + i, 7, 8'h40, 8'h40, 8'h40);
      tick();
    end
    i_valid = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    @(negedge clk);
    check("t5_write", 32'(o_mem_write), 32'd0);
    i_mem_waitrequest = 1'b0;
    wr_cnt = 0;
    repeat (12) tick();
    check("t5_stale", 32'(wr_cnt), 32'd0);

    // End of frame
    do_reset();
    fd_cnt = 0;
    wr_cnt = 0;
    for (int x = 636; x <= 640; x++) begin
      pix(x, 479, x, 2 * x, 3 * x);
      tick();
    end
    pix(0, 480, 9, 9, 9);
    tick();
    i_valid = 1'b0;
    repeat (8) tick();
    check("t4_frame_done", 32'(fd_cnt), 32'd1);
    check("t4_writes", 32'(wr_cnt), 32'd4);

    // Dither behaviour on the red channel
    do_reset();
    pix(1, 0, 8'h1C, 8'h00, 8'h00);
    tick();
    i_valid = 1'b0;
    tick();
    @(negedge clk);
`ifdef PWB_DITHER_EN
    check("t6_red_dither", 32'(o_mem_writedata[7:5]), 32'd1);
`else
    check("t6_red_plain", 32'(o_mem_writedata[7:5]), 32'd0);
`endif
    tick();
    pix(0, 1, 8'hFC, 8'h00, 8'h00);
    tick();
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t6_red_sat", 32'(o_mem_writedata[7:5]), 32'd7);
    repeat (3) tick();

    // Random traffic with stall bursts
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        pix($urandom_range(0, 9) == 0 ? 640 : $urandom_range(600, 639),
            $urandom_range(0, 9) == 0 ? 480 : $urandom_range(470, 479),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255));
      end else begin
        i_valid = 1'b0;
      end
      i_mem_waitrequest = ((c % 300) < 40) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      if (c == 2500) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    i_valid = 1'b0;
    i_mem_waitrequest = 1'b0;
    repeat (30) tick();
    check("final_idle", 32'(o_mem_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
